// File: rtl/slow_clk_pkg.sv
// Shared types and defaults for the slow-clock receiver (edge_sync + slow_clk_recv).
package slow_clk_pkg;

  typedef enum logic [2:0] {IDLE, MEASURE, TRACK, LOCKED, LOST} sc_state_t;

  localparam int SC_CNT_W   = 20;
  localparam int SC_TIMEOUT = 2**19;
  localparam int SC_TOL     = 4;

  function automatic logic [31:0] sc_abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes the asynchronous slow clock into clk, optionally glitch-filters it
// (SLOW_CLK_FILTER_EN), and emits registered 1-cycle rise/fall pulses.
module edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic slow_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
    $error("edge_sync: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev;

  // NOTE: asynchronous reset sits in the sensitivity list so it acts without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignment makes every stage sample the old value of the one before it.
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef SLOW_CLK_FILTER_EN
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FW-1:0] filt_cnt;
  logic          level_q;

  // level follows the synced input only after it has disagreed for FILT_LEN straight cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_cnt <= '0;
      level_q  <= 1'b0;
    end else if (synced == level_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      level_q  <= synced;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign level = level_q;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      prev       <= level;
      rise_pulse <= level & ~prev;
      fall_pulse <= ~level & prev;
    end
  end

endmodule

// File: rtl/slow_clk_recv.sv
// Slow-clock receiver: edge pulses in the clk domain, rise-to-rise period measurement,
// lock/loss tracking. Define SLOW_CLK_FILTER_EN to enable the FILT_LEN glitch filter.
module slow_clk_recv
  import slow_clk_pkg::*;
#(
  parameter int CNT_W       = SC_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = SC_TIMEOUT,
  parameter int TOL         = SC_TOL,
  parameter int LOCK_COUNT  = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_in,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  if (LOCK_COUNT < 1 || TIMEOUT >= 2**CNT_W) begin : g_bad_param
    $error("slow_clk_recv: LOCK_COUNT must be >= 1 and TIMEOUT < 2**CNT_W");
  end

  localparam int               MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  sc_state_t        state;
  logic [CNT_W-1:0] cnt_p;
  logic [CNT_W-1:0] cnt_e;
  logic [CNT_W-1:0] cnt_e_nxt;
  logic [CNT_W-1:0] period_new;
  logic [MW-1:0]    match;
  logic             period_ok;
  logic             timeout;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .slow_in    (slow_in),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    period_new = (cnt_p == CNT_MAX) ? CNT_MAX : cnt_p + 1'b1;
    period_ok  = sc_abs_diff(32'(period_new), 32'(period)) <= 32'(TOL);
    if (rise_pulse || fall_pulse) begin
      cnt_e_nxt = '0;
    end else if (cnt_e == CNT_MAX) begin
      cnt_e_nxt = cnt_e;
    end else begin
      cnt_e_nxt = cnt_e + 1'b1;
    end
    // Timeout fires on the edge cnt_e reaches TIMEOUT; an edge pulse clears it first.
    timeout = (cnt_e_nxt == TIMEOUT_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p <= '0;
      cnt_e <= '0;
    end else begin
      cnt_e <= cnt_e_nxt;
      if (rise_pulse) begin
        cnt_p <= '0;
      end else if (cnt_p != CNT_MAX) begin
        cnt_p <= cnt_p + 1'b1;
      end
    end
  end

  // Comparisons use the old period; the new measurement loads on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      match        <= '0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else if (rise_pulse) begin
      period <= period_new;
      case (state)
        IDLE: state <= MEASURE;
        MEASURE: begin
          state        <= TRACK;
          period_valid <= 1'b1;
          match        <= '0;
        end
        TRACK: begin
          if (period_ok) begin
            match <= match + 1'b1;
            if (match == MW'(LOCK_COUNT - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            match <= '0;
          end
        end
        LOCKED: begin
          if (!period_ok) begin
            state  <= TRACK;
            locked <= 1'b0;
            match  <= '0;
          end
        end
        LOST: begin
          state        <= MEASURE;
          period_valid <= 1'b0;
          lost         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end else if (timeout && (state inside {MEASURE, TRACK, LOCKED})) begin
      state  <= LOST;
      lost   <= 1'b1;
      locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slow_clk_recv.sv
// Scoreboard bench for slow_clk_recv: expected pulse times and post-rise status are
// queued as slow_in is driven, then popped when the DUT emits its pulses.
module tb_slow_clk_recv;
  import slow_clk_pkg::*;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 100;
  localparam int TOL         = 1;
  localparam int LOCK_COUNT  = 2;
  localparam int FILT_LEN    = 3;
  localparam int CNT_MAX     = 2**CNT_W - 1;
`ifdef SLOW_CLK_FILTER_EN
  localparam int LAT         = SYNC_STAGES + 1 + FILT_LEN;
  localparam int GLITCH_EXP  = 0;
`else
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int GLITCH_EXP  = 1;
`endif

  typedef struct {
    int period;
    bit valid;
    bit locked;
    bit lost;
  } status_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             slow_in = 1'b0;
  logic             level, rise_pulse, fall_pulse, period_valid, locked, lost;
  logic [CNT_W-1:0] period;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_rise_seen = 0;
  int n_fall_seen = 0;
  int last_fall = 0;

  int      rise_q[$];
  int      fall_q[$];
  status_t st_q[$];
  bit      st_pend = 1'b0;

  sc_state_t m_state = IDLE;
  int        m_period = 0;
  int        m_match = 0;
  bit        m_valid = 1'b0;
  int        m_last_rise = 0;
  int        m_last_edge = 0;

  slow_clk_recv #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT),
    .TOL         (TOL),
    .LOCK_COUNT  (LOCK_COUNT),
    .FILT_LEN    (FILT_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .slow_in      (slow_in),
    .level        (level),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},  32'(level), 0);
    check({tag, "_rise"},   32'(rise_pulse), 0);
    check({tag, "_fall"},   32'(fall_pulse), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_valid"},  32'(period_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_lost"},   32'(lost), 0);
  endtask

  // Event-level reference: one update per slow_in edge, using the driven gaps.
  task automatic model_edge(input bit is_rise, input int now);
    int gap_any, newp, diff;
    gap_any     = now - m_last_edge;
    m_last_edge = now;
    if (gap_any > TIMEOUT && (m_state inside {MEASURE, TRACK, LOCKED})) m_state = LOST;
    if (is_rise) begin
      newp = now - m_last_rise;
      if (newp > CNT_MAX) newp = CNT_MAX;
      m_last_rise = now;
      diff = (newp > m_period) ? newp - m_period : m_period - newp;
      case (m_state)
        IDLE:    m_state = MEASURE;
        MEASURE: begin m_state = TRACK; m_valid = 1'b1; m_match = 0; end
        TRACK: begin
          if (diff <= TOL) begin
            m_match++;
            if (m_match >= LOCK_COUNT) m_state = LOCKED;
          end else begin
            m_match = 0;
          end
        end
        LOCKED:  if (diff > TOL) begin m_state = TRACK; m_match = 0; end
        LOST:    begin m_state = MEASURE; m_valid = 1'b0; end
        default: ;
      endcase
      m_period = newp;
      st_q.push_back('{newp, m_valid, m_state == LOCKED, m_state == LOST});
    end
  endtask

  task automatic model_reset();
    m_state     = IDLE;
    m_valid     = 1'b0;
    m_match     = 0;
    m_period    = 0;
    m_last_rise = cyc;
    m_last_edge = cyc;
  endtask

  task automatic drive(input bit v, input int hold);
    @(negedge clk);
    slow_in = v;
    if (v) rise_q.push_back(cyc + LAT);
    else begin
      fall_q.push_back(cyc + LAT);
      last_fall = cyc;
    end
    model_edge(v, cyc);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic slow_cycle(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic pulse_reset(input string tag, input bit check_zero);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    if (check_zero) check_all_zero(tag);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    status_t s;
    if (st_pend) begin
      st_pend = 1'b0;
      if (st_q.size() == 0) begin
        check("status_queued", 32'(st_q.size()), 1);
      end else begin
        s = st_q.pop_front();
        check("period_valid", 32'(period_valid), 32'(s.valid));
        check("locked", 32'(locked), 32'(s.locked));
        check("lost", 32'(lost), 32'(s.lost));
        if (s.valid) check("period", 32'(period), 32'(s.period));
      end
    end
    if (rise_pulse) begin
      n_rise_seen++;
      if (rise_q.size() == 0) check("rise_unexpected", 32'(rise_pulse), 0);
      else check("rise_cycle", cyc, rise_q.pop_front());
      st_pend = 1'b1;
    end
    if (fall_pulse) begin
      n_fall_seen++;
      if (fall_q.size() == 0) check("fall_unexpected", 32'(fall_pulse), 0);
      else check("fall_cycle", cyc, fall_q.pop_front());
    end
  end

  initial begin
    int target, r0, f0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Steady period 20: lock on the 4th rise.
    repeat (6) slow_cycle(10, 10);
    check("locked_p20", 32'(locked), 1);

    // Stall while locked: loss exactly TIMEOUT cycles after the last edge is registered.
    target = last_fall + LAT + 1 + TIMEOUT;
    while (cyc < target - 1) @(negedge clk);
    check("stall_lost_early", 32'(lost), 0);
    check("stall_locked_early", 32'(locked), 1);
    @(negedge clk);
    check("stall_lost", 32'(lost), 1);
    check("stall_locked", 32'(locked), 0);
    check("stall_period_held", 32'(period), 20);
    check("stall_valid_held", 32'(period_valid), 1);
    repeat (20) @(negedge clk);
    repeat (5) slow_cycle(10, 10);
    check("relocked_p20", 32'(locked), 1);

    // Period change 20 -> 30.
    repeat (4) slow_cycle(15, 15);
    check("locked_p30", 32'(locked), 1);

    // Jitter within TOL keeps lock; outside TOL never locks.
    repeat (4) begin slow_cycle(10, 10); slow_cycle(10, 11); end
    check("locked_20_21", 32'(locked), 1);
    repeat (4) begin slow_cycle(10, 10); slow_cycle(10, 13); end
    check("locked_20_23", 32'(locked), 0);

    // Asynchronous reset while locked, then IDLE behaviour after release.
    repeat (6) slow_cycle(10, 10);
    check("locked_before_reset", 32'(locked), 1);
    pulse_reset("mid_reset", 1'b1);
    repeat (2) slow_cycle(10, 10);

    // Single-cycle glitch.
    pulse_reset("glitch_reset", 1'b0);
    repeat (3) @(negedge clk);
    r0 = n_rise_seen;
    f0 = n_fall_seen;
    @(negedge clk);
    slow_in = 1'b1;
`ifndef SLOW_CLK_FILTER_EN
    rise_q.push_back(cyc + LAT);
    model_edge(1'b1, cyc);
`endif
    @(negedge clk);
    slow_in = 1'b0;
`ifndef SLOW_CLK_FILTER_EN
    fall_q.push_back(cyc + LAT);
    model_edge(1'b0, cyc);
`endif
    repeat (20) @(negedge clk);
    check("glitch_rises", n_rise_seen - r0, GLITCH_EXP);
    check("glitch_falls", n_fall_seen - f0, GLITCH_EXP);

    check("rise_q_drained", 32'(rise_q.size()), 0);
    check("fall_q_drained", 32'(fall_q.size()), 0);
    check("status_q_drained", 32'(st_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
